// File: rtl/mem_stage.sv
// MIPS data-memory pipeline stage: little-endian byte-addressable RAM with sized,
// extended loads, lane-enabled stores, fault detection and a registered MEM/WB bundle.
module mem_stage #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WB_W       = 2,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [WB_W-1:0]  wb_mem,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       mem_size,
    input  logic             mem_unsigned,
    input  logic [31:0]      address_mem,
    input  logic [31:0]      write_data_mem,
    input  logic [REG_W-1:0] write_register_ex,
    output logic [WB_W-1:0]  wb,
    output logic [31:0]      read_data,
    output logic [31:0]      address_wb,
    output logic [REG_W-1:0] write_register_mem,
    output logic             mem_fault,
    output logic [31:0]      fault_addr,
    output logic             store_valid,
    output logic [31:0]      store_addr,
    output logic [31:0]      store_data,
    output logic [3:0]       store_be
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    function automatic logic access_fault(input logic rd, input logic wr,
                                          input logic [1:0] size, input logic [1:0] lane);
        logic misaligned;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
        return (rd | wr) & (misaligned | (rd & wr));
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = {{24{~uns & b[7]}}, b};
            2'b01:   res = {{16{~uns & h[15]}}, h};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{d[7:0]}};
            2'b01:   res = {2{d[15:0]}};
            2'b10:   res = d;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return res;
    endfunction

    logic [31:0]           ram_r [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx_s;
    logic [31:0]           ram_word_s;
    logic                  fault_s;
    logic                  load_s;
    logic                  store_s;
    logic                  ram_we_s;
    logic [31:0]           load_data_s;
    logic [31:0]           lane_data_s;
    logic [3:0]            be_s;
    logic [31:0]           merged_s;

    logic [WB_W-1:0]       wb_r;
    logic [31:0]           read_data_r;
    logic [31:0]           address_wb_r;
    logic [REG_W-1:0]      write_register_r;
    logic                  mem_fault_r;
    logic [31:0]           fault_addr_r;
    logic                  store_valid_r;
    logic [31:0]           store_addr_r;
    logic [31:0]           store_data_r;
    logic [3:0]            store_be_r;

    // Access decode, combinational RAM read and store lane preparation.
    always_comb begin
        word_idx_s  = address_mem[DEPTH_LOG2+1:2];
        ram_word_s  = ram_r[word_idx_s];
        fault_s     = access_fault(mem_read, mem_write, mem_size, address_mem[1:0]);
        load_s      = mem_read & ~fault_s;
        store_s     = mem_write & ~fault_s;
        ram_we_s    = store_s & ~stall & ~flush & ~rst;
        load_data_s = extend_load(ram_word_s, mem_size, mem_unsigned, address_mem[1:0]);
        be_s        = lane_enables(mem_size, address_mem[1:0]);
        lane_data_s = lane_replicate(mem_size, write_data_mem);
        merged_s    = merge_lanes(ram_word_s, lane_data_s, be_s);
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[word_idx_s] <= merged_s;
        end
    end

    // MEM/WB register: reset > flush > stall > normal capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_r             <= {WB_W{1'b0}};
            read_data_r      <= 32'h0000_0000;
            address_wb_r     <= 32'h0000_0000;
            write_register_r <= {REG_W{1'b0}};
            mem_fault_r      <= 1'b0;
            fault_addr_r     <= 32'h0000_0000;
            store_valid_r    <= 1'b0;
            store_addr_r     <= 32'h0000_0000;
            store_data_r     <= 32'h0000_0000;
            store_be_r       <= 4'b0000;
        end else if (flush) begin
            wb_r             <= {WB_W{1'b0}};
            read_data_r      <= 32'h0000_0000;
            address_wb_r     <= 32'h0000_0000;
            write_register_r <= {REG_W{1'b0}};
            mem_fault_r      <= 1'b0;
            store_valid_r    <= 1'b0;
        end else if (stall) begin
            mem_fault_r      <= 1'b0;
            store_valid_r    <= 1'b0;
        end else begin
            // A fault kills the writeback but still forwards address and register index.
            wb_r             <= fault_s ? {WB_W{1'b0}} : wb_mem;
            read_data_r      <= load_s ? load_data_s : 32'h0000_0000;
            address_wb_r     <= address_mem;
            write_register_r <= write_register_ex;
            mem_fault_r      <= fault_s;
            store_valid_r    <= store_s;
            if (fault_s) begin
                fault_addr_r <= address_mem;
            end
            if (store_s) begin
                store_addr_r <= {address_mem[31:2], 2'b00};
                store_data_r <= lane_data_s;
                store_be_r   <= be_s;
            end
        end
    end

    assign wb                 = wb_r;
    assign read_data          = read_data_r;
    assign address_wb         = address_wb_r;
    assign write_register_mem = write_register_r;
    assign mem_fault          = mem_fault_r;
    assign fault_addr         = fault_addr_r;
    assign store_valid        = store_valid_r;
    assign store_addr         = store_addr_r;
    assign store_data         = store_data_r;
    assign store_be           = store_be_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-array reference model compared every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_mem_stage;

    localparam int DEPTH_LOG2 = 5;
    localparam int WB_W       = 2;
    localparam int REG_W      = 5;
    localparam int MB         = 4 << DEPTH_LOG2;

    logic             clk = 1'b0;
    logic             rst, stall, flush, mem_read, mem_write, mem_unsigned;
    logic [WB_W-1:0]  wb_mem;
    logic [1:0]       mem_size;
    logic [31:0]      address_mem, write_data_mem;
    logic [REG_W-1:0] write_register_ex;
    logic [WB_W-1:0]  wb;
    logic [31:0]      read_data, address_wb, fault_addr, store_addr, store_data;
    logic [REG_W-1:0] write_register_mem;
    logic             mem_fault, store_valid;
    logic [3:0]       store_be;

    mem_stage #(.DEPTH_LOG2(DEPTH_LOG2), .WB_W(WB_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .wb_mem(wb_mem),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .address_mem(address_mem),
        .write_data_mem(write_data_mem), .write_register_ex(write_register_ex),
        .wb(wb), .read_data(read_data), .address_wb(address_wb),
        .write_register_mem(write_register_mem), .mem_fault(mem_fault),
        .fault_addr(fault_addr), .store_valid(store_valid), .store_addr(store_addr),
        .store_data(store_data), .store_be(store_be)
    );

    always #5 clk = ~clk;

    // Reference model: flat byte memory plus expected output values.
    logic [7:0]       mm [MB];
    logic [WB_W-1:0]  e_wb;
    logic [31:0]      e_rd, e_addr, e_faddr, e_saddr, e_sdata;
    logic [REG_W-1:0] e_wreg;
    logic             e_fault, e_sv;
    logic [3:0]       e_sbe;
    int               tests = 0;
    int               fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update();
        int n, base;
        logic bad;
        logic [31:0] a, v;
        if (rst) begin
            e_wb = '0; e_rd = 0; e_addr = 0; e_wreg = '0; e_fault = 0; e_faddr = 0;
            e_sv = 0; e_saddr = 0; e_sdata = 0; e_sbe = 0;
        end else if (flush) begin
            e_wb = '0; e_rd = 0; e_addr = 0; e_wreg = '0; e_fault = 0; e_sv = 0;
        end else if (stall) begin
            e_fault = 0; e_sv = 0;
        end else begin
            case (mem_size)
                2'd0:    n = 1;
                2'd1:    n = 2;
                2'd2:    n = 4;
                default: n = 0;
            endcase
            a = address_mem;
            bad = 1'b0;
            if (mem_read || mem_write) begin
                if (n == 0) bad = 1'b1;
                else if ((a % n) != 0) bad = 1'b1;
                else if (mem_read && mem_write) bad = 1'b1;
            end
            base    = int'(a % MB);
            e_wb    = bad ? '0 : wb_mem;
            e_addr  = a;
            e_wreg  = write_register_ex;
            e_fault = bad;
            if (bad) e_faddr = a;
            e_rd = 0;
            e_sv = 0;
            if (!bad && mem_read) begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (32'(mm[base+i]) << (8*i));
                if (!mem_unsigned && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                e_rd = v;
            end
            if (!bad && mem_write) begin
                for (int i = 0; i < n; i++) mm[base+i] = write_data_mem[8*i +: 8];
                e_sv    = 1'b1;
                e_saddr = a & ~32'd3;
                e_sbe   = 4'(((1 << n) - 1) << (a % 4));
                for (int k = 0; k < 4; k++) e_sdata[8*k +: 8] = write_data_mem[8*(k % n) +: 8];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("wb", 32'(wb), 32'(e_wb));
        chk("read_data", read_data, e_rd);
        chk("address_wb", address_wb, e_addr);
        chk("write_register_mem", 32'(write_register_mem), 32'(e_wreg));
        chk("mem_fault", 32'(mem_fault), 32'(e_fault));
        chk("fault_addr", fault_addr, e_faddr);
        chk("store_valid", 32'(store_valid), 32'(e_sv));
        if (e_sv) begin
            chk("store_addr", store_addr, e_saddr);
            chk("store_data", store_data, e_sdata);
            chk("store_be", 32'(store_be), 32'(e_sbe));
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic [1:0] wbv,
                         input logic [4:0] rg, input logic st, input logic fl, input logic rs);
        mem_read = r; mem_write = w; mem_size = sz; mem_unsigned = u;
        address_mem = a; write_data_mem = d; wb_mem = wbv; write_register_ex = rg;
        stall = st; flush = fl; rst = rs;
        step();
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, 2'd2, 1'b0, a, d, 2'b01, 5'd1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a);
        drive(1'b1, 1'b0, sz, u, a, 32'h0, 2'b11, 5'd9, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 2'b10, 5'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lit_rd(input string name, input logic [31:0] exp);
        chk(name, read_data, exp);
        chk({"model_", name}, e_rd, exp);
    endtask

    initial begin
        for (int i = 0; i < MB; i++) mm[i] = 8'h00;
        e_faddr = 0; e_saddr = 0; e_sdata = 0; e_sbe = 0;

        // Reset state
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_wb", 32'(wb), 32'h0);
        chk("reset_read_data", read_data, 32'h0);
        chk("reset_fault_addr", fault_addr, 32'h0);
        chk("reset_store_be", 32'(store_be), 32'h0);

        for (int w = 0; w < MB / 4; w++) sw(32'(w * 4), $urandom);
        sw(32'h30, 32'h0); sw(32'h34, 32'h0); sw(32'h38, 32'h0); sw(32'h3C, 32'h0);

        // Word store and load
        sw(32'h10, 32'hDEADBEEF);
        chk("sw_store_be", 32'(store_be), 32'hF);
        chk("sw_store_addr", store_addr, 32'h10);
        chk("sw_store_valid", 32'(store_valid), 32'h1);
        ld(2'd2, 1'b0, 32'h10);
        lit_rd("lw_0x10", 32'hDEADBEEF);

        // Byte/half extension
        sw(32'h10, 32'h80FF7F01);
        ld(2'd0, 1'b0, 32'h13); lit_rd("lb_0x13", 32'hFFFFFF80);
        ld(2'd0, 1'b1, 32'h13); lit_rd("lbu_0x13", 32'h00000080);
        ld(2'd1, 1'b0, 32'h12); lit_rd("lh_0x12", 32'hFFFF80FF);
        ld(2'd1, 1'b1, 32'h10); lit_rd("lhu_0x10", 32'h00007F01);

        // Partial store
        sw(32'h10, 32'h0);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AB, 2'b01, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("sb_store_be", 32'(store_be), 32'h2);
        chk("sb_store_data", store_data, 32'hABABABAB);
        ld(2'd2, 1'b0, 32'h10); lit_rd("lw_after_sb", 32'h0000AB00);

        // Misalignment
        sw(32'h20, 32'h11223344);
        ld(2'd2, 1'b0, 32'h22);
        chk("lw_mis_fault", 32'(mem_fault), 32'h1);
        chk("lw_mis_fault_addr", fault_addr, 32'h22);
        chk("lw_mis_wb", 32'(wb), 32'h0);
        chk("lw_mis_read_data", read_data, 32'h0);
        idle();
        chk("fault_pulse_drop", 32'(mem_fault), 32'h0);
        chk("fault_addr_sticky", fault_addr, 32'h22);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000FFFF, 2'b01, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("sh_mis_fault", 32'(mem_fault), 32'h1);
        chk("sh_mis_store_valid", 32'(store_valid), 32'h0);
        ld(2'd2, 1'b0, 32'h20); lit_rd("ram_unchanged_0x20", 32'h11223344);

        // Stall holds a store until released, then one commit
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 2'b01, 5'd1, 1'b1, 1'b0, 1'b0);
            chk("stall_store_valid", 32'(store_valid), 32'h0);
        end
        sw(32'h30, 32'hCAFEF00D);
        chk("stall_release_store_valid", 32'(store_valid), 32'h1);
        ld(2'd2, 1'b0, 32'h30);
        chk("stall_single_pulse", 32'(store_valid), 32'h0);
        lit_rd("lw_after_stall", 32'hCAFEF00D);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h34, 32'h55555555, 2'b01, 5'd1, 1'b1, 1'b0, 1'b0);
        ld(2'd2, 1'b0, 32'h34); lit_rd("stalled_store_dropped", 32'h0);

        // Flush with stall gives a bubble and no write
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h38, 32'h77, 2'b11, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("flush_wb", 32'(wb), 32'h0);
        chk("flush_wreg", 32'(write_register_mem), 32'h0);
        chk("flush_store_valid", 32'(store_valid), 32'h0);
        ld(2'd2, 1'b0, 32'h38); lit_rd("flushed_store_dropped", 32'h0);

        // Reset during a store
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h3C, 32'h99, 2'b11, 5'd7, 1'b0, 1'b0, 1'b1);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_address_wb", address_wb, 32'h0);
        chk("rst_store_addr", store_addr, 32'h0);
        chk("rst_store_data", store_data, 32'h0);
        ld(2'd2, 1'b0, 32'h3C); lit_rd("rst_store_dropped", 32'h0);

        // Aliasing of upper address bits
        sw(32'h80, 32'h13579BDF);
        ld(2'd2, 1'b0, 32'h00); lit_rd("alias_0x80_0x00", 32'h13579BDF);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            logic r, w, u, st, fl, rs;
            logic [1:0] sz;
            logic [31:0] a;
            int kind;
            kind = int'($urandom_range(0, 19));
            r  = (kind < 8) || (kind == 19);
            w  = (kind >= 8 && kind < 16) || (kind == 19);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            u  = 1'($urandom_range(0, 1));
            a  = {($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'h0, 8'($urandom)};
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) begin
                a = a & ~((32'd1 << sz) - 32'd1);
            end
            st = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 49) == 0);
            drive(r, w, sz, u, a, $urandom, 2'($urandom), 5'($urandom), st, fl, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised MIPS data-memory pipeline stage sitting between EX/MEM and MEM/WB. It holds an internal little-endian, byte-addressable data RAM and performs byte, halfword and word loads and stores, with sign/zero extension and per-lane byte enables. It detects misaligned or illegal accesses and supports pipeline stall and flush. It registers the writeback bundle for the WB stage with one cycle of latency.

## Interface
Parameters:
- DEPTH_LOG2, 5: log2 of RAM depth in 32-bit words (default 32 words).
- WB_W, 2: width of the writeback control bundle.
- REG_W, 5: width of the destination register index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- stall  in  1  hold all output registers; suppress memory write and fault.
- flush  in  1  discard the instruction in MEM; insert a bubble.
- wb_mem  in  WB_W  writeback control from EX/MEM.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- address_mem  in  32  byte address (also the ALU result passed to WB).
- write_data_mem  in  32  store data, right-aligned.
- write_register_ex  in  REG_W  destination register.
- wb  out  WB_W  registered writeback control.
- read_data  out  32  registered, extended load data.
- address_wb  out  32  registered address_mem.
- write_register_mem  out  REG_W  registered destination register.
- mem_fault  out  1  one-cycle pulse on a faulting access.
- fault_addr  out  32  address of the most recent fault (sticky).
- store_valid  out  1  one-cycle pulse when a store committed.
- store_addr  out  32  word-aligned address of the committed store.
- store_data  out  32  lane-aligned store data.
- store_be  out  4  byte enables of the committed store.

## Operation
- **Word index and aliasing.** Word index = address_mem[DEPTH_LOG2+1:2]. Upper address bits are ignored, so out-of-range addresses alias.
- **Byte lanes.** Lane k holds bits [8k+7:8k]. Byte lane = addr[1:0]. Halfword lanes = {addr[1],0} and {addr[1],1}.
- **Fault conditions.** An access faults if any of these holds:
  - mem_size=11 with mem_read or mem_write set;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - mem_read and mem_write both set.
- **Fault response.**
  - No RAM write.
  - read_data=0.
  - wb forced to 0, which kills the writeback.
  - mem_fault=1.
  - fault_addr ← address_mem.
- **Load.**
  - The RAM is read combinationally at the word index and the lane is selected.
  - Byte: the lane is extended to 32 bits per mem_unsigned.
  - Half: the halfword is extended to 32 bits per mem_unsigned.
  - Word: passed through.
  - The result is registered into read_data.
- **Store.**
  - Byte: write_data_mem[7:0] is replicated to all four lanes; be = one-hot at addr[1:0].
  - Half: [15:0] is replicated to both halves; be = 0011 or 1100.
  - Word: be = 1111.
  - Only enabled lanes of the RAM word update.
  - store_valid/addr/data/be are registered at the same edge.
- **No access** (mem_read=mem_write=0): read_data=0; wb, address_wb and write_register_mem pass through.
- **Priority**, highest first: rst > flush > stall > normal.
  - flush: all WB outputs ← 0, no write, no fault, store_valid=0.
  - stall: WB outputs and fault_addr hold; mem_fault=0, store_valid=0, no write.
- **Reset.** Reset does not clear RAM contents. RAM is initially undefined; the bench preloads it via a hierarchical reference or by using stores.

## Timing
- Reset values: wb, read_data, address_wb, write_register_mem, mem_fault, fault_addr, store_valid, store_addr, store_data and store_be are all 0.
- Latency: inputs sampled at edge N appear on the WB outputs after edge N. There is one register stage, with no combinational path from inputs to outputs.
- A store sampled at edge N updates the RAM at edge N. A load presented in the following cycle returns the new data, so there is no hazard for back-to-back store→load to the same word.
- mem_fault and store_valid are single-cycle pulses. They are 0 on any cycle whose edge was a stall, flush or reset.
- If rst is asserted mid-stream, the in-flight store on that edge is suppressed.

## Test plan
- **Word store and load.** Store 0xDEADBEEF to 0x10, then load word at 0x10 → read_data=0xDEADBEEF one cycle after the load edge; store_be=1111 and store_addr=0x10 on the store.
- **Byte/half extension.** With word 0x10 = 0x80FF7F01, load:
  - lb 0x13 → 0xFFFFFF80;
  - lbu 0x13 → 0x00000080;
  - lh 0x12 → 0xFFFF80FF;
  - lhu 0x10 → 0x00007F01.
- **Partial store.** sb 0xAB to 0x11 onto 0x00000000 → store_be=0010, store_data=0xABABABAB; a following lw at 0x10 returns 0x0000AB00.
- **Misalignment.** lw at 0x22 → mem_fault pulse, fault_addr=0x22, wb=0, read_data=0. sh at 0x21 → fault and RAM unchanged.
- **Stall/flush priority.**
  - A store held under stall for 3 cycles → a single RAM write and one store_valid once stall drops.
  - flush with stall together → bubble (wb=0, write_register_mem=0) and no write.
- **Reset and aliasing.**
  - rst during a store → no write; all outputs 0 the next cycle.
  - With DEPTH_LOG2=5, a store to 0x80 → a load at 0x00 returns the same value.
